param_updown_counter: RTL and testbench
=======================================

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter and bound width, WIDTH >= 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port n_rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  run request; sampled in IDLE only.
REQ-005 SHALL have port stop  input  1  abort; sampled in LOAD and RUN.
REQ-006 SHALL have port up_down  input  1  direction latched at start: 1 = up, 0 = down.
REQ-007 SHALL have port en  input  1  count enable in RUN: 0 = pause and hold.
REQ-008 SHALL have port lo  input  WIDTH  lower bound, latched at start.
REQ-009 SHALL have port hi  input  WIDTH  upper bound, latched at start.
REQ-010 SHALL have port cnt  output  WIDTH  registered count value.
REQ-011 SHALL have port busy  output  1  high in LOAD and RUN.
REQ-012 SHALL have port done  output  1  one-cycle pulse in DONE.
REQ-013 SHALL have port err  output  1  one-cycle pulse in ERR.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, RUN, DONE, ERR; all outputs decoded from registered state or registered cnt.
REQ-015 IDLE: if start=1 and stop=0, SHALL latch lo, hi, up_down and go to ERR when lo > hi (unsigned), else to LOAD; otherwise stay IDLE with cnt held.
REQ-016 LOAD: SHALL set cnt to lo_q when up, or hi_q when down, then go to RUN, all in one cycle.
REQ-017 RUN with en=1: SHALL step cnt by +1 when up or -1 when down; with en=0, cnt and state SHALL hold.
REQ-018 RUN: when cnt equals the end value (hi_q up, lo_q down) and en=1, SHALL go to DONE with cnt held; cnt SHALL never leave [lo_q, hi_q] and SHALL never wrap.
REQ-019 DONE and ERR SHALL each last exactly one cycle and then return to IDLE.
REQ-020 Latency: start high at edge k → LOAD after k; first count value after k+1. With en held high, DONE is entered (hi_q - lo_q + 1) edges after LOAD.
REQ-021 lo == hi SHALL load that value and reach DONE on the first enabled RUN edge.
REQ-022 stop=1 in LOAD or RUN SHALL go to IDLE next edge, with cnt held and no done pulse; stop takes priority over every transition.
REQ-023 start while busy SHALL be ignored; latched bounds and direction SHALL NOT change mid-run.

Reset
REQ-024 n_rst=0 SHALL asynchronously force IDLE with cnt=0, busy=0, done=0, err=0, lo_q=0, hi_q=0, and dir_q=1, including mid-run.
REQ-025 After n_rst deasserts, the first start SHALL be honoured on the next rising edge.

Configuration
REQ-026 With macro PARAM_UPDOWN_COUNTER_BOUNCE_EN defined, the end value reached in RUN SHALL reverse direction instead of finishing; cnt SHALL hold for zero extra cycles (next enabled step goes the other way), and DONE SHALL follow on reaching the start value. lo == hi SHALL go to DONE immediately.
REQ-027 Without the macro, the bounce logic SHALL be absent and behaviour SHALL follow REQ-018.

Structure
REQ-028 Shared package param_updown_counter_pkg SHALL hold the state enum typedef (3-bit encoding) and the direction constants DIR_UP=1 and DIR_DOWN=0.
REQ-029 The bound comparison (lo>hi check, end-value match) SHALL be a sub-module cnt_bound_cmp parametrised by WIDTH; everything else stays in param_updown_counter.

Verification (WIDTH=8)
REQ-030 lo=3, hi=6, up_down=1, en=1, start pulse -> cnt 3,4,5,6; done pulses once; busy falls when done rises.
REQ-031 lo=3, hi=6, up_down=0 -> cnt 6,5,4,3, then done; then lo=hi=5 -> cnt 5, done on the next edge.
REQ-032 lo=7, hi=2, start -> err pulses one cycle, busy never rises, cnt unchanged.
REQ-033 Up run 0..255 with en low for 3 cycles at cnt=100 -> cnt holds 100 for 3 cycles, no wrap past 255, then done; stop at cnt=150 on a second run -> IDLE, cnt=150, no done.
REQ-034 n_rst low mid-run at cnt=40 -> cnt=0 and busy=0 immediately, without waiting for a clock edge; start ignored while busy (bounds change has no effect).
REQ-035 With PARAM_UPDOWN_COUNTER_BOUNCE_EN, lo=3, hi=6, up -> cnt 3,4,5,6,5,4,3, then done.

Source files
------------

// File: rtl/param_updown_counter_pkg.sv
// Shared types and constants for the bounded up/down counter.
package param_updown_counter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/param_updown_counter_bound_cmp.sv
// Bound comparisons for the counter: bad-bounds check and end/start value matches.
// The start-value match exists only with PARAM_UPDOWN_COUNTER_BOUNCE_EN.
module cnt_bound_cmp
  import param_updown_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] lo_q,
  input  logic [WIDTH-1:0] hi_q,
  input  logic             dir_q,
`ifdef PARAM_UPDOWN_COUNTER_BOUNCE_EN
  output logic             at_start,
`endif
  output logic             bad_bounds,
  output logic             at_end
);

  logic [WIDTH-1:0] end_val;

  assign end_val    = (dir_q == DIR_UP) ? hi_q : lo_q;
  assign bad_bounds = lo > hi;
  assign at_end     = cnt == end_val;

`ifdef PARAM_UPDOWN_COUNTER_BOUNCE_EN
  // start value of the current leg; equals end_val when lo_q == hi_q
  assign at_start = cnt == ((dir_q == DIR_UP) ? lo_q : hi_q);
`endif

endmodule

// File: rtl/param_updown_counter.sv
// Bounded up/down counter with start/stop/pause control and done/err pulses.
// Optional PARAM_UPDOWN_COUNTER_BOUNCE_EN: reverse at the end value, finish back at the start value.
//
// state | meaning
// IDLE  | waiting for start, cnt held
// LOAD  | cnt <= start value (lo_q up, hi_q down)
// RUN   | stepping toward end value while en=1
// DONE  | one-cycle done pulse
// ERR   | one-cycle err pulse, lo > hi at start
module param_updown_counter
  import param_updown_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             stop,
  input  logic             up_down,
  input  logic             en,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             dir_q, dir_d;
  logic             bad_bounds;
  logic             at_end;
`ifdef PARAM_UPDOWN_COUNTER_BOUNCE_EN
  logic             at_start;
  logic             bounced_q, bounced_d;
`endif

  cnt_bound_cmp #(.WIDTH(WIDTH)) u_bound_cmp (
    .lo         (lo),
    .hi         (hi),
    .cnt        (cnt_q),
    .lo_q       (lo_q),
    .hi_q       (hi_q),
    .dir_q      (dir_q),
`ifdef PARAM_UPDOWN_COUNTER_BOUNCE_EN
    .at_start   (at_start),
`endif
    .bad_bounds (bad_bounds),
    .at_end     (at_end)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      dir_q     <= DIR_UP;
`ifdef PARAM_UPDOWN_COUNTER_BOUNCE_EN
      bounced_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      dir_q     <= dir_d;
`ifdef PARAM_UPDOWN_COUNTER_BOUNCE_EN
      bounced_q <= bounced_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    dir_d     = dir_q;
`ifdef PARAM_UPDOWN_COUNTER_BOUNCE_EN
    bounced_d = bounced_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          lo_d    = lo;
          hi_d    = hi;
          dir_d   = up_down;
          state_d = bad_bounds ? ST_ERR : ST_LOAD;
`ifdef PARAM_UPDOWN_COUNTER_BOUNCE_EN
          bounced_d = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = (dir_q == DIR_UP) ? lo_q : hi_q;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (en) begin
          if (at_end) begin
`ifdef PARAM_UPDOWN_COUNTER_BOUNCE_EN
            if (bounced_q || at_start) begin
              state_d = ST_DONE;
            end else begin
              // turn around on this same edge so the end value shows for one cycle only
              bounced_d = 1'b1;
              dir_d     = ~dir_q;
              cnt_d     = (dir_q == DIR_UP) ? cnt_q - 1'b1 : cnt_q + 1'b1;
            end
`else
            state_d = ST_DONE;
`endif
          end else begin
            cnt_d = (dir_q == DIR_UP) ? cnt_q + 1'b1 : cnt_q - 1'b1;
          end
        end
      end
      ST_DONE, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  assign cnt  = cnt_q;
  assign busy = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign done = state_q == ST_DONE;
  assign err  = state_q == ST_ERR;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter (WIDTH=8) with an expected-count queue.
module tb_param_updown_counter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start;
  logic         stop;
  logic         up_down;
  logic         en;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic [W-1:0] cnt;
  logic         busy;
  logic         done;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(W)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start),
    .stop    (stop),
    .up_down (up_down),
    .en      (en),
    .lo      (lo),
    .hi      (hi),
    .cnt     (cnt),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push_seq(input int l, input int h, input bit d);
    if (d) for (int v = l; v <= h; v++) exp_q.push_back(v);
    else   for (int v = h; v >= l; v--) exp_q.push_back(v);
`ifdef PARAM_UPDOWN_COUNTER_BOUNCE_EN
    if (l != h) begin
      if (d) for (int v = h - 1; v >= l; v--) exp_q.push_back(v);
      else   for (int v = l + 1; v <= h; v++) exp_q.push_back(v);
    end
`endif
  endtask

  task automatic start_run(input int l, input int h, input bit d);
    lo      = l[W-1:0];
    hi      = h[W-1:0];
    up_down = d;
    start   = 1'b1;
    cyc();
    start   = 1'b0;
  endtask

  // Called in LOAD; pops one expected count per RUN cycle until busy drops.
  task automatic run_expect(input int budget, input int exp_done, input int pause_at, input int stop_at);
    bit prev;
    bit paused;
    bit fin;
    int dn;
    int hold;
    prev = busy; paused = 0; fin = 0; dn = 0; hold = 0;
    check("load_busy", busy, 1);
    for (int i = 0; i < budget && !fin; i++) begin
      cyc();
      if (busy && prev) begin
        if (exp_q.size() == 0) check("scoreboard_underrun", exp_q.size(), 1);
        else                   check("cnt", cnt, exp_q.pop_front());
        if (hold > 0) begin
          hold--;
          if (hold == 0) en = 1'b1;
        end else if (!paused && cnt == pause_at) begin
          en = 1'b0; hold = 3; paused = 1;
        end
        if (cnt == stop_at) stop = 1'b1;
      end
      if (done) begin
        dn++;
        check("busy_at_done", busy, 0);
      end
      if (!busy && prev) fin = 1;
      prev = busy;
    end
    stop = 1'b0;
    en   = 1'b1;
    check("run_finished", fin, 1);
    check("scoreboard_drained", exp_q.size(), 0);
    check("done_pulses", dn, exp_done);
    check("err_quiet", err, 0);
    cyc();
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
    exp_q.delete();
  endtask

  initial begin
    logic [W-1:0] c0;
    n_rst = 1'b0; start = 1'b0; stop = 1'b0; up_down = 1'b1; en = 1'b1;
    lo = '0; hi = '0;
    cyc();
    check("rst_cnt", cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    n_rst = 1'b1;

    // up 3..6 straight after reset release
    push_seq(3, 6, 1);
    start_run(3, 6, 1);
    run_expect(40, 1, -1, -1);

    // down 6..3, then lo == hi
    push_seq(3, 6, 0);
    start_run(3, 6, 0);
    run_expect(40, 1, -1, -1);
    push_seq(5, 5, 0);
    start_run(5, 5, 0);
    run_expect(20, 1, -1, -1);

    // lo > hi
    c0 = cnt;
    start_run(7, 2, 1);
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_cnt", cnt, c0);
    cyc();
    check("err_one_cycle", err, 0);
    check("err_busy_after", busy, 0);
    check("err_cnt_after", cnt, c0);

    // full range with a 3-cycle pause at 100
    for (int v = 0; v <= 100; v++) exp_q.push_back(v);
    for (int k = 0; k < 3; k++) exp_q.push_back(100);
    for (int v = 101; v <= 255; v++) exp_q.push_back(v);
`ifdef PARAM_UPDOWN_COUNTER_BOUNCE_EN
    for (int v = 254; v >= 0; v--) exp_q.push_back(v);
`endif
    start_run(0, 255, 1);
    run_expect(700, 1, 100, -1);

    // stop at 150
    for (int v = 0; v <= 150; v++) exp_q.push_back(v);
    start_run(0, 255, 1);
    run_expect(400, 0, -1, 150);
    check("stop_cnt_held", cnt, 150);

    // stop during LOAD
    c0 = cnt;
    start_run(10, 20, 1);
    check("stopload_busy", busy, 1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("stopload_idle", busy, 0);
    check("stopload_cnt", cnt, c0);
    check("stopload_done", done, 0);

    // start while busy ignored, then async reset at 40
    for (int v = 0; v <= 40; v++) exp_q.push_back(v);
    start_run(0, 255, 1);
    for (int i = 0; i < 41; i++) begin
      cyc();
      check("busy_run_cnt", cnt, exp_q.pop_front());
      start = 1'b0;
      if (i == 20) begin
        start = 1'b1; lo = 8'd200; hi = 8'd210; up_down = 1'b0;
      end
    end
    #1 n_rst = 1'b0;
    #1;
    check("async_rst_cnt", cnt, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    cyc();
    n_rst = 1'b1;

    // first start after reset release
    push_seq(3, 4, 1);
    start_run(3, 4, 1);
    run_expect(30, 1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
